// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with same-cycle lookup,
// per-entry saturating direction counters, per-set round-robin victim and global flush.
`default_nettype none

module btb_assoc #(
    parameter int ADDR_WIDTH = 64,
    parameter int SETS       = 16,
    parameter int WAYS       = 2,
    parameter int TAG_WIDTH  = 20,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_if,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  flush
);

    localparam int IDX_BITS = $clog2(SETS);
    localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TGT_BITS = ADDR_WIDTH - 2;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [WAY_BITS-1:0] WAY_LAST = WAY_BITS'(WAYS - 1);

    logic [WAYS-1:0]      valid_q [SETS];
    logic [TAG_WIDTH-1:0] tag_q   [SETS][WAYS];
    logic [TGT_BITS-1:0]  tgt_q   [SETS][WAYS];
    logic [CTR_BITS-1:0]  ctr_q   [SETS][WAYS];
    logic [WAY_BITS-1:0]  vic_q   [SETS];

    logic [IDX_BITS-1:0]  lk_idx, up_idx;
    logic [TAG_WIDTH-1:0] lk_tag, up_tag;

    assign lk_idx = pc_if[IDX_BITS+1:2];
    assign lk_tag = pc_if[IDX_BITS+TAG_WIDTH+1:IDX_BITS+2];
    assign up_idx = upd_pc[IDX_BITS+1:2];
    assign up_tag = upd_pc[IDX_BITS+TAG_WIDTH+1:IDX_BITS+2];

    // Upper PC bits and the low two bits of every address are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{pc_if, upd_pc, upd_target[1:0]};

    always_comb begin
        pred_hit    = 1'b0;
        pred_taken  = 1'b0;
        pred_target = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
                pred_hit    = 1'b1;
                pred_taken  = ctr_q[lk_idx][w][CTR_BITS-1];
                pred_target = {tgt_q[lk_idx][w], 2'b00};
            end
        end
    end

    logic                upd_hit;
    logic [WAY_BITS-1:0] hit_way;
    logic                has_free;
    logic [WAY_BITS-1:0] free_way;
    logic [WAY_BITS-1:0] alloc_way;
    logic [WAY_BITS-1:0] vic_d;
    logic [CTR_BITS-1:0] ctr_cur, ctr_d;

    always_comb begin
        upd_hit  = 1'b0;
        hit_way  = '0;
        has_free = 1'b0;
        free_way = '0;
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
                upd_hit = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!valid_q[up_idx][w]) begin
                has_free = 1'b1;
                free_way = WAY_BITS'(w);
            end
        end
        alloc_way = has_free ? free_way : vic_q[up_idx];
        vic_d     = (vic_q[up_idx] == WAY_LAST) ? '0 : vic_q[up_idx] + 1'b1;
        ctr_cur   = ctr_q[up_idx][hit_way];
        if (upd_taken) begin
            ctr_d = (ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + 1'b1;
        end else begin
            ctr_d = (ctr_cur == '0) ? ctr_cur : ctr_cur - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                vic_q[s]   <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w] <= '0;
                    tgt_q[s][w] <= '0;
                    ctr_q[s][w] <= '0;
                end
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                vic_q[s]   <= '0;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_q[up_idx][hit_way] <= ctr_d;
                if (upd_taken) begin
                    tgt_q[up_idx][hit_way] <= upd_target[ADDR_WIDTH-1:2];
                end
            end else if (upd_taken) begin
                valid_q[up_idx][alloc_way] <= 1'b1;
                tag_q[up_idx][alloc_way]   <= up_tag;
                tgt_q[up_idx][alloc_way]   <= upd_target[ADDR_WIDTH-1:2];
                ctr_q[up_idx][alloc_way]   <= CTR_WEAK;
                if (!has_free) begin
                    vic_q[up_idx] <= vic_d;
                end
            end
        end
    end

endmodule

`default_nettype wire
